// File: rtl/axi_sram_slave_burst.sv
// AXI4 memory slave wrapping a single-port synchronous SRAM.
// One transaction is in flight at a time: a read or write burst is granted
// from IDLE, serviced to completion, then control returns to IDLE. Read and
// write grants alternate when both sides are requesting.
module axi_sram_slave_burst #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   i_arid,
  input  logic [31:0]       i_araddr,
  input  logic [3:0]        i_arlen,
  input  logic [1:0]        i_arburst,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [ID_W-1:0]   o_rid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic              o_rvalid,
  input  logic              i_rready,
  input  logic [ID_W-1:0]   i_awid,
  input  logic [31:0]       i_awaddr,
  input  logic [3:0]        i_awlen,
  input  logic [1:0]        i_awburst,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic              i_wlast,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [ID_W-1:0]   o_bid,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready
);

  localparam int NB    = DATA_W / 8;
  localparam int LNB   = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_WR    = 2'd2;
  localparam logic [1:0] S_WRESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  logic [1:0]        r_state;
  logic              r_prio;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic [1:0]        r_burst;
  logic              r_err;
  logic [4:0]        r_cnt;
  logic              r_qvalid;
  logic              r_qlast;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_arready;
  logic w_awready;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_advance;
  logic w_issue;
  logic w_whs;
  logic [ADDR_W-1:0] w_next_addr;

  // A burst errors if it addresses beyond the memory, uses the reserved
  // burst type, or is a WRAP whose length is not a power of two.
  function automatic logic burstErr(input logic [31:0] a, input logic [3:0] len,
                                    input logic [1:0] b);
    logic hi;
    logic legalWrap;
    hi = |(a >> (ADDR_W + LNB));
    legalWrap = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return hi || (b == 2'd3) || ((b == 2'd2) && !legalWrap);
  endfunction

  // Word-index sequencing: WRAP lengths are 2^n-1, so LEN doubles as the
  // wrap mask over the word index.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a,
                                                 input logic [3:0] len,
                                                 input logic [1:0] b);
    logic [ADDR_W-1:0] m;
    m = ADDR_W'(len);
    case (b)
      2'd0:    return a;
      2'd2:    return (a & ~m) | ((a + ADDR_W'(1)) & m);
      default: return a + ADDR_W'(1);
    endcase
  endfunction

  assign w_arready   = !rst && (r_state == S_IDLE) && (!r_prio || !i_awvalid);
  assign w_awready   = !rst && (r_state == S_IDLE) && (r_prio || !i_arvalid);
  assign w_ar_hs     = i_arvalid && w_arready;
  assign w_aw_hs     = i_awvalid && w_awready;
  assign w_advance   = !o_rvalid || i_rready;
  assign w_issue     = (r_state == S_RD) && w_advance && (r_cnt <= {1'b0, r_len});
  assign w_whs       = i_wvalid && o_wready;
  assign w_next_addr = nextAddr(r_addr, r_len, r_burst);

  assign o_arready = w_arready;
  assign o_awready = w_awready;
  assign o_wready  = (r_state == S_WR);

  // Transaction control: grant, address/beat sequencing and write response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_prio   <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_burst  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      o_bvalid <= 1'b0;
      o_bresp  <= RESP_OKAY;
      o_bid    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_id    <= i_arid;
            r_addr  <= i_araddr[ADDR_W+LNB-1:LNB];
            r_len   <= i_arlen;
            r_burst <= i_arburst;
            r_err   <= burstErr(i_araddr, i_arlen, i_arburst);
            r_cnt   <= '0;
            r_prio  <= 1'b1;
            r_state <= S_RD;
          end else if (w_aw_hs) begin
            r_id    <= i_awid;
            r_addr  <= i_awaddr[ADDR_W+LNB-1:LNB];
            r_len   <= i_awlen;
            r_burst <= i_awburst;
            r_err   <= burstErr(i_awaddr, i_awlen, i_awburst);
            r_cnt   <= '0;
            r_prio  <= 1'b0;
            r_state <= S_WR;
          end
        end
        S_RD: begin
          if (w_issue) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 5'd1;
          end
          if (o_rvalid && i_rready && o_rlast) begin
            r_state <= S_IDLE;
          end
        end
        S_WR: begin
          if (w_whs) begin
            r_addr <= w_next_addr;
            if (r_cnt != 5'd31) begin
              r_cnt <= r_cnt + 5'd1;
            end
            if (i_wlast) begin
              r_state  <= S_WRESP;
              o_bvalid <= 1'b1;
              o_bid    <= r_id;
              o_bresp  <= (r_err || (r_cnt != {1'b0, r_len})) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: begin
          if (i_bready) begin
            o_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Two-stage read pipeline (SRAM output, then R channel) that freezes as a whole on an R stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qvalid <= 1'b0;
      r_qlast  <= 1'b0;
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
      o_rdata  <= '0;
      o_rresp  <= RESP_OKAY;
      o_rid    <= '0;
    end else if (w_advance) begin
      r_qvalid <= w_issue;
      r_qlast  <= (r_cnt == {1'b0, r_len});
      o_rvalid <= r_qvalid;
      o_rlast  <= r_qvalid && r_qlast;
      if (r_qvalid) begin
        o_rdata <= r_err ? '0 : r_q;
        o_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
        o_rid   <= r_id;
      end
    end
  end

  // Single-port SRAM: registered read, byte-masked write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_q <= r_mem[r_addr];
    end
    if (w_whs && !r_err) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) begin
          r_mem[r_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave_burst.sv
// Testbench for axi_sram_slave_burst: directed scenarios plus randomized
// bursts, all checked against a word-array memory model and burst address
// rules computed with plain arithmetic.
module tb_axi_sram_slave_burst;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int ID_W   = 8;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ID_W-1:0]   arId = '0;
  logic [31:0]       arAddr = '0;
  logic [3:0]        arLen = '0;
  logic [1:0]        arBurst = '0;
  logic              arValid = 1'b0;
  logic              arReady;
  logic [ID_W-1:0]   rId;
  logic [DATA_W-1:0] rData;
  logic [1:0]        rResp;
  logic              rLast;
  logic              rValid;
  logic              rReady = 1'b0;
  logic [ID_W-1:0]   awId = '0;
  logic [31:0]       awAddr = '0;
  logic [3:0]        awLen = '0;
  logic [1:0]        awBurst = '0;
  logic              awValid = 1'b0;
  logic              awReady;
  logic [DATA_W-1:0] wData = '0;
  logic [NB-1:0]     wStrb = '0;
  logic              wLast = 1'b0;
  logic              wValid = 1'b0;
  logic              wReady;
  logic [ID_W-1:0]   bId;
  logic [1:0]        bResp;
  logic              bValid;
  logic              bReady = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mdl [DEPTH];

  always #5 clk = ~clk;

  axi_sram_slave_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .i_arid(arId), .i_araddr(arAddr), .i_arlen(arLen), .i_arburst(arBurst),
    .i_arvalid(arValid), .o_arready(arReady),
    .o_rid(rId), .o_rdata(rData), .o_rresp(rResp), .o_rlast(rLast),
    .o_rvalid(rValid), .i_rready(rReady),
    .i_awid(awId), .i_awaddr(awAddr), .i_awlen(awLen), .i_awburst(awBurst),
    .i_awvalid(awValid), .o_awready(awReady),
    .i_wdata(wData), .i_wstrb(wStrb), .i_wlast(wLast), .i_wvalid(wValid),
    .o_wready(wReady),
    .o_bid(bId), .o_bresp(bResp), .o_bvalid(bValid), .i_bready(bReady)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Bursts that address beyond the memory, use type 3, or WRAP with a
  // non-power-of-two beat count are errors.
  function automatic bit isErr(input logic [31:0] addr, input int len, input int burst);
    return (addr >= 32'(DEPTH * NB)) || (burst == 3) ||
           ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Word touched by a given beat of a burst.
  function automatic int wordAt(input logic [31:0] addr, input int len, input int burst, input int beat);
    int start;
    int size;
    int base;
    start = int'(addr / NB) % DEPTH;
    case (burst)
      0: return start;
      2: begin
        size = len + 1;
        base = start - (start % size);
        return base + ((start % size) + beat) % size;
      end
      default: return (start + beat) % DEPTH;
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {arReady, awReady, rValid, rLast, rData, rResp, rId, wReady, bValid, bResp, bId}, 64'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    arValid = 0; awValid = 0; wValid = 0; wLast = 0; rReady = 0; bReady = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic readBurst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input int burst, input bit stallMode, output logic [DATA_W-1:0] firstData);
    bit err;
    bit seenFirst;
    bit stalled;
    int cyc;
    int beat;
    int wi;
    logic [DATA_W-1:0] heldData;
    logic heldLast;
    logic [DATA_W-1:0] expData;
    err = isErr(addr, len, burst);
    firstData = '0;
    heldData = '0;
    heldLast = 1'b0;
    @(negedge clk);
    arId = id; arAddr = addr; arLen = 4'(len); arBurst = 2'(burst); arValid = 1'b1; rReady = 1'b0;
    cyc = 0;
    #1;
    while (!arReady && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (!arReady) begin
      checkOutput("arReadyTimeout", arReady, 1);
      arValid = 1'b0;
      return;
    end
    @(negedge clk);
    arValid = 1'b0;
    cyc = 0; beat = 0; seenFirst = 0; stalled = 0;
    while (beat <= len && cyc < 300) begin
      rReady = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rValid) begin
        if (!seenFirst) begin
          seenFirst = 1;
          checkOutput("rLatency", cyc, 2);
        end
        if (stalled) begin
          checkOutput("rHoldData", rData, heldData);
          checkOutput("rHoldLast", rLast, heldLast);
        end
        if (rReady) begin
          wi = wordAt(addr, len, burst, beat);
          expData = err ? '0 : mdl[wi];
          checkOutput("rData", rData, expData);
          checkOutput("rResp", rResp, err ? 2 : 0);
          checkOutput("rLast", rLast, (beat == len) ? 1 : 0);
          checkOutput("rId", rId, id);
          if (beat == 0) firstData = rData;
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          heldData = rData;
          heldLast = rLast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rReady = 1'b0;
    if (beat <= len) checkOutput("rBeatsTimeout", beat, len + 1);
    else begin
      #1;
      checkOutput("rIdleAfterLast", rValid, 0);
    end
  endtask

  task automatic writeBurst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input int burst, input int nbeats, input logic [DATA_W-1:0] data0,
                            input logic [NB-1:0] strb0, input bit randData);
    bit err;
    bit done;
    int cyc;
    int wi;
    err = isErr(addr, len, burst);
    @(negedge clk);
    awId = id; awAddr = addr; awLen = 4'(len); awBurst = 2'(burst); awValid = 1'b1;
    cyc = 0;
    #1;
    while (!awReady && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (!awReady) begin
      checkOutput("awReadyTimeout", awReady, 1);
      awValid = 1'b0;
      return;
    end
    @(negedge clk);
    awValid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wData  = randData ? DATA_W'($urandom) : data0 + DATA_W'(i);
      wStrb  = randData ? NB'($urandom) : strb0;
      wLast  = (i == nbeats - 1);
      wValid = 1'b1;
      cyc = 0;
      #1;
      while (!wReady && cyc < 50) begin
        @(negedge clk); #1; cyc++;
      end
      if (!wReady) begin
        checkOutput("wReadyTimeout", wReady, 1);
        wValid = 1'b0;
        wLast = 1'b0;
        return;
      end
      if (!err) begin
        wi = wordAt(addr, len, burst, i);
        for (int b = 0; b < NB; b++) begin
          if (wStrb[b]) mdl[wi][b*8 +: 8] = wData[b*8 +: 8];
        end
      end
      @(negedge clk);
    end
    wValid = 1'b0;
    wLast = 1'b0;
    done = 0;
    cyc = 0;
    while (!done && cyc < 50) begin
      bReady = 1'($urandom_range(0, 1));
      #1;
      if (bValid && bReady) begin
        checkOutput("bResp", bResp, (err || nbeats != len + 1) ? 2 : 0);
        checkOutput("bId", bId, id);
        done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bReady = 1'b0;
    if (!done) checkOutput("bValidTimeout", bValid, 1);
  endtask

  // Randomized mix of reads and writes over the pre-filled memory regions.
  task automatic applyStimulus(input int count);
    logic [31:0] addr;
    logic [DATA_W-1:0] d;
    int word;
    int len;
    int burst;
    int nbeats;
    for (int t = 0; t < count; t++) begin
      len = $urandom_range(0, 15);
      burst = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        addr = 32'h0001_0000 + 32'($urandom_range(0, 4095));
      end else begin
        word = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 47) : DEPTH - 8 + $urandom_range(0, 7);
        addr = 32'(word * NB + $urandom_range(0, NB - 1));
      end
      if ($urandom_range(0, 1) == 1) begin
        readBurst(ID_W'($urandom), addr, len, burst, 1'($urandom_range(0, 1)), d);
      end else begin
        case ($urandom_range(0, 5))
          0:       nbeats = len + 2;
          1:       nbeats = (len > 0) ? len : 2;
          default: nbeats = len + 1;
        endcase
        writeBurst(ID_W'($urandom), addr, len, burst, nbeats, '0, '0, 1'b1);
      end
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    int ng;
    int cyc;
    logic [63:0] grant;

    #1 rst = 1'b1;
    #1 checkAllZero("resetOutputs");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] filling memory regions");
    for (int k = 0; k < 4; k++) writeBurst(8'h01, 32'(k * 64), 15, 1, 16, '0, '0, 1'b1);
    writeBurst(8'h02, 32'((DEPTH - 16) * NB), 15, 1, 16, '0, '0, 1'b1);

    $display("[TB] INCR read and WRAP read");
    writeBurst(8'h11, 32'h10, 3, 1, 4, 32'hA0, 4'hF, 1'b0);
    readBurst(8'h22, 32'h10, 3, 1, 1'b0, d);
    checkOutput("incrFirstBeat", d, 32'hA0);
    readBurst(8'h33, 32'h18, 3, 2, 1'b0, d);
    checkOutput("wrapFirstBeat", d, 32'hA2);

    $display("[TB] byte strobes");
    writeBurst(8'h44, 32'h0, 0, 1, 1, 32'h1122_3344, 4'hF, 1'b0);
    writeBurst(8'h45, 32'h0, 0, 1, 1, 32'hFFFF_FFFF, 4'b0101, 1'b0);
    readBurst(8'h46, 32'h0, 0, 1, 1'b0, d);
    checkOutput("strobeReadback", d, 32'h11FF_33FF);

    $display("[TB] out-of-range accesses");
    readBurst(8'h55, 32'h0001_0000, 3, 1, 1'b0, d);
    writeBurst(8'h56, 32'h0001_0000, 1, 1, 2, 32'hDEAD_BEEF, 4'hF, 1'b0);
    readBurst(8'h57, 32'h0, 0, 1, 1'b0, d);
    checkOutput("oorWriteIgnored", d, 32'h11FF_33FF);
    writeBurst(8'h58, 32'h40, 3, 1, 3, 32'h5000, 4'hF, 1'b0);

    $display("[TB] arbitration with both sides requesting");
    applyReset();
    arId = 8'h61; arAddr = 32'h0; arLen = 0; arBurst = 1;
    awId = 8'h62; awAddr = 32'h4; awLen = 0; awBurst = 1;
    wStrb = '0; wData = '0; wLast = 1'b1; wValid = 1'b1; rReady = 1'b1; bReady = 1'b1;
    @(negedge clk);
    arValid = 1'b1; awValid = 1'b1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 100) begin
      #1;
      if ((arValid && arReady) || (awValid && awReady)) begin
        grant = (awValid && awReady) ? 64'd1 : 64'd0;
        checkOutput("arbOrder", grant, 64'(ng % 2));
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("arbGrantCount", ng, 4);
    arValid = 1'b0; awValid = 1'b0;
    repeat (6) @(negedge clk);
    wValid = 1'b0; wLast = 1'b0; rReady = 1'b0; bReady = 1'b0;

    $display("[TB] stalled read");
    readBurst(8'h71, 32'h20, 15, 1, 1'b1, d);

    $display("[TB] reset in the middle of a burst");
    @(negedge clk);
    arId = 8'h81; arAddr = 32'h0; arLen = 15; arBurst = 1; arValid = 1'b1; rReady = 1'b1;
    cyc = 0;
    #1;
    while (!arReady && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    checkOutput("midArReady", arReady, 1);
    @(negedge clk);
    arValid = 1'b0;
    repeat (4) @(negedge clk);
    #1 checkOutput("midBurstValid", rValid, 1);
    rst = 1'b1;
    #1 checkAllZero("midBurstReset");
    @(negedge clk);
    rReady = 1'b0;
    rst = 1'b0;
    arValid = 1'b1; awValid = 1'b1;
    #1;
    checkOutput("postResetArReady", arReady, 1);
    checkOutput("postResetAwReady", awReady, 0);
    arValid = 1'b0; awValid = 1'b0;

    $display("[TB] randomized bursts");
    applyStimulus(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave_burst.md
Name:
axi_sram_slave_burst

Overview:
Parametrised AXI4 slave with an internal single-port synchronous SRAM. It is the next-generation memory wrapper: configurable data/ID/depth widths, FIXED/INCR/WRAP bursts, byte strobes, SLVERR on bad accesses, and fair read/write arbitration. It sits on the bus as an instruction or data memory slave.

Parameters:
DATA_W, 32, data bus width in bits; power of two, at least 16; NB = DATA_W/8 bytes per beat.
ADDR_W, 14, memory word-address width; DEPTH = 2**ADDR_W words.
ID_W, 8, slave-side ID width.

Ports:
clk  in  1  clock
rst  in  1  reset
ARID  in  ID_W  read ID
ARADDR  in  32  read byte address
ARLEN  in  4  beats minus 1
ARBURST  in  2  0 FIXED, 1 INCR, 2 WRAP
ARVALID  in  1  AR valid
ARREADY  out  1  AR ready
RID  out  ID_W  read ID echo
RDATA  out  DATA_W  read data
RRESP  out  2  0 OKAY, 2 SLVERR
RLAST  out  1  last read beat
RVALID  out  1  R valid
RREADY  in  1  R ready
AWID  in  ID_W  write ID
AWADDR  in  32  write byte address
AWLEN  in  4  beats minus 1
AWBURST  in  2  burst type
AWVALID  in  1  AW valid
AWREADY  out  1  AW ready
WDATA  in  DATA_W  write data
WSTRB  in  NB  byte enables, 1 = write the byte
WLAST  in  1  last write beat
WVALID  in  1  W valid
WREADY  out  1  W ready
BID  out  ID_W  write ID echo
BRESP  out  2  write response
BVALID  out  1  B valid
BREADY  in  1  B ready

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. During reset all outputs are 0 (READY and VALID signals, RLAST, RDATA, RRESP, BRESP, RID, BID). FSM goes to IDLE and the priority flag to read. Memory contents are not reset.
- FSM states: IDLE, RD, WR, WRESP; exactly one transaction is in flight at a time.
- IDLE, ready signals: ARREADY and AWREADY are combinational.
  - ARREADY = IDLE & (prio==read | !AWVALID).
  - AWREADY = IDLE & (prio==write | !ARVALID).
- Priority: the flag toggles to the other side after each granted transaction.
- Handshake latch: on an AR or AW handshake, latch ID, address, LEN and BURST.
- Address check: SLVERR if address bits [31 : ADDR_W+log2(NB)] are non-zero, if BURST==3, or if BURST==WRAP with LEN not in {1,3,7,15}. The SLVERR verdict applies to the whole burst.
- Address sequence:
  - FIXED: constant address.
  - INCR: add NB per beat; the word index wraps modulo DEPTH.
  - WRAP: wrap at an aligned boundary of (LEN+1)*NB bytes.
  - The low log2(NB) address bits are ignored.
- RD timing: the first RVALID is asserted 2 cycles after the AR handshake (the synchronous SRAM read is registered). With RREADY held high, throughput is 1 beat per cycle.
- RD stall: while RVALID & !RREADY, RDATA/RRESP/RLAST/RID stay stable and no new SRAM read is issued.
- RD end: RLAST = 1 on beat LEN. The handshake on the RLAST beat returns to IDLE. RDATA = 0 and RRESP = SLVERR on error bursts.
- WR: WREADY = 1. Each W handshake writes the enabled bytes at the current address in the same cycle. Error bursts write nothing.
- WR to WRESP: on the WLAST handshake, go to WRESP and assert BVALID. BRESP = SLVERR if the burst errored or if the beat count != LEN+1; otherwise OKAY.
- WRESP: BVALID holds until BREADY, then return to IDLE. WREADY = 0 outside WR.
- No read/write collision is possible, because the FSM is exclusive.

Test Plan:
- Reset, then AR addr 0x10, LEN 3, INCR, after writing words 4..7 = 0xA0..0xA3 -> RDATA A0,A1,A2,A3; RLAST on the 4th beat; first RVALID 2 cycles after AR.
- WRAP read, addr 0x18, LEN 3 -> word order 6,7,4,5; RRESP OKAY.
- Write 0x11223344 to addr 0x0, then write with WSTRB 0b0101 and data 0xFFFFFFFF -> readback 0x11FF33FF; BRESP OKAY with BID echoed.
- Read addr 0x00010000 (out of range) -> LEN+1 beats with RRESP=2 and RDATA=0; memory untouched.
- ARVALID and AWVALID both asserted every cycle from reset -> grants alternate R, W, R, W; neither side starves.
- RREADY toggled 1-0-1 mid-burst -> data stays held during the stall; no beat lost or duplicated. Assert rst mid-burst -> all outputs go to 0 immediately and the FSM is in IDLE.
